// File: rtl/regfile_writeback_arbiter.sv
// Register file write-port arbiter.
// Merges the W-stage result stream with buffered long-latency (mul/div) results
// into the single register file write port, and tracks outstanding long-latency
// destinations in a per-register pending-write mask for decode hazard checks.
module regfile_writeback_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  // W-stage result
  input  logic                          pipe_we,
  input  logic [ADDR_W-1:0]             pipe_addr,
  input  logic [DATA_W-1:0]             pipe_data,
  // Long-latency unit result
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_W-1:0]             lu_addr,
  input  logic [DATA_W-1:0]             lu_data,
  // Long-latency issue (marks destination pending)
  input  logic                          issue_valid,
  input  logic [ADDR_W-1:0]             issue_addr,
  output logic [(2**ADDR_W)-1:0]        busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  // Register file write port
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_addr,
  output logic [DATA_W-1:0]             rf_wdata
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [PtrW-1:0] PtrLast   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] RegZero = '0;

  // Result buffer storage and control
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q,  count_d;

  // Scoreboard and registered write port
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              pipe_sel;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Wrap a pointer modulo FIFO_DEPTH (also correct for non-power-of-2 depths).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrLast) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PtrW'(1);
    end
  endfunction

  // Handshake and per-cycle arbitration decisions
  always_comb begin
    fifo_empty = (count_q == '0);
    // Ready comes from the registered count only; a full buffer refuses even when
    // a pop happens in the same cycle.
    lu_ready   = (count_q < DepthCnt);
    push       = lu_valid && lu_ready;
    // A pipe write to reg 0 is a no-op and must not steal the port from the FIFO.
    pipe_sel   = pipe_we && (pipe_addr != RegZero);
    pop        = !pipe_sel && !fifo_empty;
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
  end

  // Buffer pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending-write mask next-state: clear on pop, then set on issue so a newer op wins
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write port next-state: pipe first, then buffer head, else idle
  always_comb begin
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_sel) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (pop && (head_addr != RegZero)) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = head_addr;
      rf_wdata_d = head_data;
    end
  end

  // Buffer payload storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lu_addr;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  // Control state with synchronous reset; reset discards buffered results
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Registered outputs
  always_comb begin
    busy       = busy_q;
    fifo_count = count_q;
    rf_we      = rf_we_q;
    rf_addr    = rf_addr_q;
    rf_wdata   = rf_wdata_q;
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_writeback_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  pipe_we;
  logic [AW-1:0]         pipe_addr;
  logic [DW-1:0]         pipe_data;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [AW-1:0]         lu_addr;
  logic [DW-1:0]         lu_data;
  logic                  issue_valid;
  logic [AW-1:0]         issue_addr;
  logic [(2**AW)-1:0]    busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  rf_we;
  logic [AW-1:0]         rf_addr;
  logic [DW-1:0]         rf_wdata;

  regfile_writeback_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_addr   (pipe_addr),
    .pipe_data   (pipe_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_addr     (lu_addr),
    .lu_data     (lu_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t          mq[$];
  bit            m_busy[32];
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  bit            m_acc;
  bit            m_was_reset;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance the model using the inputs presented before the edge, clock the DUT,
  // then compare every output against the model.
  task automatic tick();
    ent_t e;
    bit   pw;
    bit   popping;
    bit   ready;
    logic [31:0] mb;
    m_acc = 0;
    m_was_reset = reset;
    if (reset) begin
      mq.delete();
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
      exp_we = 0; exp_addr = '0; exp_data = '0;
    end else begin
      ready   = (mq.size() < DEPTH);
      pw      = pipe_we && (pipe_addr != 0);
      popping = !pw && (mq.size() > 0);
      if (popping) e = mq.pop_front();
      if (pw) begin
        exp_we = 1; exp_addr = pipe_addr; exp_data = pipe_data;
      end else if (popping && e.a != 0) begin
        exp_we = 1; exp_addr = e.a; exp_data = e.d;
      end else begin
        exp_we = 0;
      end
      if (popping) m_busy[e.a] = 0;
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1;
      if (lu_valid && ready) begin
        mq.push_back('{a: lu_addr, d: lu_data});
        m_acc = 1;
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) mb[r] = m_busy[r];
    chk("rf_we", 64'(rf_we), 64'(exp_we));
    if (exp_we || m_was_reset) begin
      chk("rf_addr", 64'(rf_addr), 64'(exp_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(exp_data));
    end
    chk("busy", 64'(busy), 64'(mb));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("lu_ready", 64'(lu_ready), 64'(mq.size() < DEPTH));
  endtask

  initial begin
    reset = 1; pipe_we = 0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 0; lu_addr = '0; lu_data = '0; issue_valid = 0; issue_addr = '0;
    tick();
    tick();
    chk("reset_we", 64'(rf_we), 64'd0);
    reset = 0;
    tick();
    chk("reset_ready", 64'(lu_ready), 64'd1);

    // Pipe write, one cycle latency, then idle
    pipe_we = 1; pipe_addr = 5; pipe_data = 32'hDEADBEEF;
    tick();
    chk("t1_addr", 64'(rf_addr), 64'd5);
    chk("t1_data", 64'(rf_wdata), 64'hDEADBEEF);
    pipe_we = 0;
    tick();
    chk("t1_idle", 64'(rf_we), 64'd0);

    // Issue then long-latency result: write one edge after acceptance
    issue_valid = 1; issue_addr = 7;
    tick();
    issue_valid = 0;
    tick();
    chk("t2_busy_set", 64'(busy[7]), 64'd1);
    lu_valid = 1; lu_addr = 7; lu_data = 32'h1234;
    tick();
    lu_valid = 0;
    chk("t2_no_bypass", 64'(rf_we), 64'd0);
    chk("t2_busy_held", 64'(busy[7]), 64'd1);
    tick();
    chk("t2_we", 64'(rf_we), 64'd1);
    chk("t2_data", 64'(rf_wdata), 64'h1234);
    chk("t2_busy_clr", 64'(busy[7]), 64'd0);

    // Pipe busy for 4 cycles while two results arrive; drain in order afterwards
    pipe_we = 1; pipe_addr = 1; pipe_data = 32'h11;
    lu_valid = 1; lu_addr = 10; lu_data = 32'hA0;
    tick();
    lu_addr = 11; lu_data = 32'hB0; pipe_addr = 2;
    tick();
    lu_valid = 0;
    chk("t3_full_ready", 64'(lu_ready), 64'd0);
    chk("t3_full_count", 64'(fifo_count), 64'd2);
    pipe_addr = 3;
    tick();
    pipe_addr = 4;
    tick();
    pipe_we = 0;
    tick();
    chk("t3_first", 64'(rf_addr), 64'd10);
    tick();
    chk("t3_second", 64'(rf_addr), 64'd11);

    // Pipe write to reg 0 lets the buffer drain; buffered reg 0 result is dropped
    pipe_we = 1; pipe_addr = 1; pipe_data = 32'h22;
    lu_valid = 1; lu_addr = 3; lu_data = 32'h55;
    tick();
    lu_valid = 0; pipe_addr = 0;
    tick();
    chk("t4_we", 64'(rf_we), 64'd1);
    chk("t4_addr", 64'(rf_addr), 64'd3);
    pipe_addr = 2;
    lu_valid = 1; lu_addr = 0; lu_data = 32'h9;
    tick();
    lu_valid = 0; pipe_we = 0;
    tick();
    chk("t4_r0_we", 64'(rf_we), 64'd0);
    chk("t4_r0_cnt", 64'(fifo_count), 64'd0);

    // Set wins over clear on the same register
    issue_valid = 1; issue_addr = 9;
    tick();
    issue_valid = 0;
    pipe_we = 1; pipe_addr = 1;
    lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
    tick();
    lu_valid = 0; pipe_we = 0;
    issue_valid = 1; issue_addr = 9;
    tick();
    issue_valid = 0;
    chk("t5_busy9", 64'(busy[9]), 64'd1);

    // Reset with a full buffer and pending bits
    issue_valid = 1; issue_addr = 7;
    pipe_we = 1; pipe_addr = 6;
    lu_valid = 1; lu_addr = 12; lu_data = 32'hC;
    tick();
    issue_valid = 0; lu_addr = 13;
    tick();
    lu_valid = 0;
    chk("t6_pre_count", 64'(fifo_count), 64'd2);
    reset = 1;
    tick();
    reset = 0; pipe_we = 0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_ready", 64'(lu_ready), 64'd1);
    chk("t6_we", 64'(rf_we), 64'd0);

    // Randomized traffic; lu payload holds until accepted
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(99) == 0);
      pipe_we     = ($urandom_range(1) == 1);
      pipe_addr   = ($urandom_range(3) == 0) ? 5'd0 : AW'($urandom);
      pipe_data   = $urandom;
      issue_valid = ($urandom_range(4) == 0);
      issue_addr  = AW'($urandom);
      if (!lu_valid && $urandom_range(2) == 0) begin
        lu_valid = 1;
        lu_addr  = ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom);
        lu_data  = $urandom;
      end
      tick();
      if (m_acc) lu_valid = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
